// File: rtl/reg_bank_s8_ctl_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_s8_ctl_pkg
// Shared definitions for the 8x8 register-bank instruction initiator:
//   - instruction width and opcode constants (NOP, RDO, LD0..LD7)
//   - host command kind encoding
//   - controller FSM state encoding
//   - small helpers to build instruction words
// ---------------------------------------------------------------------------
package reg_bank_s8_ctl_pkg;

  localparam int INST_W = 12;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP = 4'd0;
  localparam opcode_t OP_RDO = 4'd1;
  localparam opcode_t OP_LD0 = 4'd2;
  localparam opcode_t OP_LD1 = 4'd3;
  localparam opcode_t OP_LD2 = 4'd4;
  localparam opcode_t OP_LD3 = 4'd5;
  localparam opcode_t OP_LD4 = 4'd6;
  localparam opcode_t OP_LD5 = 4'd7;
  localparam opcode_t OP_LD6 = 4'd8;
  localparam opcode_t OP_LD7 = 4'd9;

  typedef enum logic [1:0] {
    KIND_LOAD    = 2'd0,
    KIND_SELECT  = 2'd1,
    KIND_BULK    = 2'd2,
    KIND_ILLEGAL = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_BURST   = 3'd2,
    ST_FINAL   = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  // Opcode of the load instruction targeting register n.
  function automatic opcode_t op_ld(input logic [2:0] n);
    return OP_LD0 + opcode_t'(n);
  endfunction

  // Pack an opcode and its 8-bit immediate into one instruction word.
  function automatic logic [INST_W-1:0] mk_inst(input opcode_t op, input logic [7:0] imm);
    return {op, imm};
  endfunction

endpackage

// File: rtl/reg_bank_s8_ctl_pacer.sv
// ---------------------------------------------------------------------------
// reg_bank_s8_ctl_pacer
// Burst pacing helper: tracks which burst slot (0..7) was last issued and
// how many idle cycles remain before the next slot may be issued.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start_i  in   begin a burst; slot 0 is being issued this cycle
//   step_i   in   burst in progress; advance the gap/slot bookkeeping
//   fire_o   out  gap has elapsed: the next instruction may be issued now
//   last_o   out  the slot most recently issued was slot 7
//   idx_o    out  slot most recently issued
//
// The slot index stops at 7 (no wrap); the gap counter reloads to Gap after
// every issued slot.
// ---------------------------------------------------------------------------
module reg_bank_s8_ctl_pacer #(
  parameter int Gap = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic       step_i,
  output logic       fire_o,
  output logic       last_o,
  output logic [2:0] idx_o
);

  localparam logic [3:0] GAP_LOAD = 4'(Gap);

  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;

  assign fire_o = (gap_q == 4'd0);
  assign last_o = (idx_q == 3'd7);
  assign idx_o  = idx_q;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    idx_d = idx_q;
    gap_d = gap_q;
    if (start_i) begin
      idx_d = 3'd0;
      gap_d = GAP_LOAD;
    end else if (step_i) begin
      if (gap_q != 4'd0) begin
        gap_d = gap_q - 4'd1;
      end else if (!last_o) begin
        idx_d = idx_q + 3'd1;
        gap_d = GAP_LOAD;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q <= 3'd0;
      gap_q <= 4'd0;
    end else begin
      idx_q <= idx_d;
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/reg_bank_s8_ctl.sv
// ---------------------------------------------------------------------------
// reg_bank_s8_ctl
// Initiator for the 12-bit register-bank instruction interface. Converts
// host commands into the inst/inst_en stream of an 8x8 register bank:
// single-register LOAD, output SELECT, and BULK load of all eight registers
// from one 64-bit word followed by an output select.
//
// Parameters:
//   StartupCycles  cycles inst_en stays low after reset release (>= 1)
//   BurstGap       idle cycles between consecutive burst instructions (0..15)
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   cmd_valid   in   host command valid
//   cmd_ready   out  command accepted when cmd_valid & cmd_ready
//   cmd_kind    in   0=LOAD, 1=SELECT, 2=BULK, 3=illegal
//   cmd_index   in   target register / output select
//   cmd_data    in   LOAD uses [7:0]; BULK byte n -> register n
//   inst        out  [11:8] opcode, [7:0] immediate/select
//   inst_en     out  inst valid this cycle
//   busy        out  high whenever not in Idle
//   done        out  pulse in the cycle after a command's last instruction
//   error       out  sticky, set on an illegal command kind
//   shadow_out  out  (REG_BANK_S8_CTL_SHADOW_EN only) model of the bank's out
//
// Build option: define REG_BANK_S8_CTL_SHADOW_EN to add shadow registers
// that track what the bank holds and expose the selected one on shadow_out.
// ---------------------------------------------------------------------------
module reg_bank_s8_ctl
  import reg_bank_s8_ctl_pkg::*;
#(
  parameter int StartupCycles = 2,
  parameter int BurstGap      = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [2:0]        cmd_index,
  input  logic [63:0]       cmd_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_en,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef REG_BANK_S8_CTL_SHADOW_EN
 ,output logic [7:0]        shadow_out
`endif
);

  localparam logic [7:0] STARTUP_LOAD = 8'(StartupCycles);

  state_e              state_q;
  logic [7:0]          startup_cnt_q;
  logic [INST_W-1:0]   inst_q;
  logic                inst_en_q;
  logic                done_q;
  logic                error_q;
  logic [63:0]         data_q;
  logic [2:0]          sel_q;

  logic                pace_start;
  logic                pace_step;
  logic                pace_fire;
  logic                pace_last;
  logic [2:0]          pace_idx;
  logic [2:0]          next_idx;
  logic                accept;
  cmd_kind_e           kind;

  assign kind       = cmd_kind_e'(cmd_kind);
  assign accept     = (state_q == ST_IDLE) && cmd_valid;
  assign pace_start = accept && (kind == KIND_BULK);
  assign pace_step  = (state_q == ST_BURST);
  assign next_idx   = pace_idx + 3'd1;

  reg_bank_s8_ctl_pacer #(
    .Gap (BurstGap)
  ) u_pacer (
    .clock   (clock),
    .reset   (reset),
    .start_i (pace_start),
    .step_i  (pace_step),
    .fire_o  (pace_fire),
    .last_o  (pace_last),
    .idx_o   (pace_idx)
  );

  // Ready/busy decode straight from the state register, so they change only
  // on clock edges.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign inst      = inst_q;
  assign inst_en   = inst_en_q;
  assign done      = done_q;
  assign error     = error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_STARTUP;
      startup_cnt_q <= STARTUP_LOAD;
      inst_q        <= '0;
      inst_en_q     <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      data_q        <= '0;
      sel_q         <= '0;
    end else begin
      // Single-cycle strobes default low; inst holds its last value.
      inst_en_q <= 1'b0;
      done_q    <= 1'b0;

      unique case (state_q)
        ST_STARTUP: begin
          startup_cnt_q <= startup_cnt_q - 8'd1;
          if (startup_cnt_q <= 8'd1) begin
            state_q <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (cmd_valid) begin
            unique case (kind)
              KIND_LOAD: begin
                inst_q    <= mk_inst(op_ld(cmd_index), cmd_data[7:0]);
                inst_en_q <= 1'b1;
                state_q   <= ST_FINAL;
              end
              KIND_SELECT: begin
                inst_q    <= mk_inst(OP_RDO, {5'b0, cmd_index});
                inst_en_q <= 1'b1;
                state_q   <= ST_FINAL;
              end
              KIND_BULK: begin
                // LD0 goes out immediately to keep accept-to-inst latency at 1.
                data_q    <= cmd_data;
                sel_q     <= cmd_index;
                inst_q    <= mk_inst(OP_LD0, cmd_data[7:0]);
                inst_en_q <= 1'b1;
                state_q   <= ST_BURST;
              end
              default: begin
                error_q <= 1'b1;
                state_q <= ST_ERROR;
              end
            endcase
          end
        end

        ST_BURST: begin
          if (pace_fire) begin
            inst_en_q <= 1'b1;
            if (pace_last) begin
              inst_q  <= mk_inst(OP_RDO, {5'b0, sel_q});
              state_q <= ST_FINAL;
            end else begin
              inst_q <= mk_inst(op_ld(next_idx), data_q[{next_idx, 3'b000} +: 8]);
            end
          end
        end

        // The command's last instruction is on the bus this cycle.
        ST_FINAL: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end

        ST_ERROR: begin
          state_q <= ST_ERROR;
        end

        default: begin
          state_q <= ST_ERROR;
        end
      endcase
    end
  end

`ifdef REG_BANK_S8_CTL_SHADOW_EN
  // Shadow copy of the bank: updated on the edge at which the bank samples
  // an issued instruction, so shadow_out tracks the bank's output.
  logic [7:0][7:0] shadow_q, shadow_d;
  logic [2:0]      shadow_sel_q, shadow_sel_d;
  logic [7:0]      shadow_out_q;
  opcode_t         issued_op;
  logic [2:0]      ld_slot;

  always_comb begin
    shadow_d     = shadow_q;
    shadow_sel_d = shadow_sel_q;
    issued_op    = inst_q[11:8];
    // LDn opcodes are 2..9, so the low three bits minus 2 (mod 8) give n.
    ld_slot      = issued_op[2:0] - 3'd2;
    if (inst_en_q) begin
      if (issued_op == OP_RDO) begin
        shadow_sel_d = inst_q[2:0];
      end else if (issued_op >= OP_LD0) begin
        shadow_d[ld_slot] = inst_q[7:0];
      end
    end
  end

  // NOTE: the shadow array is explicitly reset because its contents are
  // architecturally visible (all zero after reset); plain data storage that
  // is always written before being read would not need it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_q     <= '0;
      shadow_sel_q <= '0;
      shadow_out_q <= '0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_sel_q <= shadow_sel_d;
      shadow_out_q <= shadow_d[shadow_sel_d];
    end
  end

  assign shadow_out = shadow_out_q;
`endif

endmodule

// File: tb/tb_reg_bank_s8_ctl.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_s8_ctl
// Directed bench for reg_bank_s8_ctl. Two instances share all inputs:
// index 0 uses BurstGap=0, index 1 uses BurstGap=2 (both StartupCycles=2).
// ---------------------------------------------------------------------------
module tb_reg_bank_s8_ctl;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_kind;
  logic [2:0]  cmd_index;
  logic [63:0] cmd_data;

  logic        cmd_ready_w [2];
  logic [11:0] inst_w      [2];
  logic        inst_en_w   [2];
  logic        busy_w      [2];
  logic        done_w      [2];
  logic        error_w     [2];
`ifdef REG_BANK_S8_CTL_SHADOW_EN
  logic [7:0]  shadow_w    [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] BULK_DATA = 64'h0807_0605_0403_0201;

  reg_bank_s8_ctl #(.StartupCycles(2), .BurstGap(0)) u_dut0 (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready_w[0]),
    .cmd_kind  (cmd_kind),
    .cmd_index (cmd_index),
    .cmd_data  (cmd_data),
    .inst      (inst_w[0]),
    .inst_en   (inst_en_w[0]),
    .busy      (busy_w[0]),
    .done      (done_w[0]),
    .error     (error_w[0])
`ifdef REG_BANK_S8_CTL_SHADOW_EN
   ,.shadow_out(shadow_w[0])
`endif
  );

  reg_bank_s8_ctl #(.StartupCycles(2), .BurstGap(2)) u_dut1 (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready_w[1]),
    .cmd_kind  (cmd_kind),
    .cmd_index (cmd_index),
    .cmd_data  (cmd_data),
    .inst      (inst_w[1]),
    .inst_en   (inst_en_w[1]),
    .busy      (busy_w[1]),
    .done      (done_w[1]),
    .error     (error_w[1])
`ifdef REG_BANK_S8_CTL_SHADOW_EN
   ,.shadow_out(shadow_w[1])
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) until both instances are in Idle.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready_w[0] && cmd_ready_w[1]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_kind  = 2'd0;
    cmd_index = 3'd3;
    cmd_data  = 64'h0000_0000_0000_00A5;
    #1 reset = 1'b0;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (inst_w[d] !== 12'h000 || inst_en_w[d] !== 1'b0 || cmd_ready_w[d] !== 1'b0 ||
          busy_w[d] !== 1'b1 || done_w[d] !== 1'b0 || error_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_values dut%0d: inst=%h en=%b rdy=%b busy=%b done=%b err=%b, want 000 0 0 1 0 0",
                 d, inst_w[d], inst_en_w[d], cmd_ready_w[d], busy_w[d], done_w[d], error_w[d]);
      end
    end
    reset = 1'b1;
    // Two startup cycles with cmd_ready low, then Idle.
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (cmd_ready_w[d] !== 1'b0 || inst_en_w[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL startup_cycle%0d dut%0d: rdy=%b en=%b, want 0 0", c, d, cmd_ready_w[d], inst_en_w[d]);
        end
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (cmd_ready_w[d] !== 1'b1 || busy_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL startup_end dut%0d: rdy=%b busy=%b, want 1 0", d, cmd_ready_w[d], busy_w[d]);
      end
    end
    step();  // accept edge for the held LOAD
    cmd_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (inst_w[d] !== 12'h5A5 || inst_en_w[d] !== 1'b1 || cmd_ready_w[d] !== 1'b0 || done_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL load_inst dut%0d: inst=%h en=%b rdy=%b done=%b, want 5a5 1 0 0",
                 d, inst_w[d], inst_en_w[d], cmd_ready_w[d], done_w[d]);
      end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (done_w[d] !== 1'b1 || inst_en_w[d] !== 1'b0 || cmd_ready_w[d] !== 1'b1 || busy_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL load_done dut%0d: done=%b en=%b rdy=%b busy=%b, want 1 0 1 0",
                 d, done_w[d], inst_en_w[d], cmd_ready_w[d], busy_w[d]);
      end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (done_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL load_done_pulse dut%0d: done=%b, want 0", d, done_w[d]);
      end
    end
  endtask

  task automatic test_select();
    bit ok;
    wait_ready(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL select_wait_ready: ready=0 after 60 cycles, want 1");
    end
    cmd_valid = 1'b1;
    cmd_kind  = 2'd1;
    cmd_index = 3'd6;
    step();
    cmd_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (inst_w[d] !== 12'h106 || inst_en_w[d] !== 1'b1 || busy_w[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL select_inst dut%0d: inst=%h en=%b busy=%b, want 106 1 1", d, inst_w[d], inst_en_w[d], busy_w[d]);
      end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b1 || error_w[d] !== 1'b0 || inst_en_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL select_done dut%0d: busy=%b done=%b err=%b en=%b, want 0 1 0 0",
                 d, busy_w[d], done_w[d], error_w[d], inst_en_w[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_ready(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL b2b_wait_ready: ready=0 after 60 cycles, want 1");
    end
    cmd_valid = 1'b1;
    cmd_kind  = 2'd0;
    cmd_index = 3'd0;
    cmd_data  = 64'h11;
    step();
    cmd_kind  = 2'd1;  // SELECT 2 offered immediately, held valid
    cmd_index = 3'd2;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (inst_w[d] !== 12'h211 || inst_en_w[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_first dut%0d: inst=%h en=%b, want 211 1", d, inst_w[d], inst_en_w[d]);
      end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (done_w[d] !== 1'b1 || cmd_ready_w[d] !== 1'b1 || inst_en_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_done_ready dut%0d: done=%b rdy=%b en=%b, want 1 1 0", d, done_w[d], cmd_ready_w[d], inst_en_w[d]);
      end
    end
    step();
    cmd_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (inst_w[d] !== 12'h102 || inst_en_w[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_second dut%0d: inst=%h en=%b, want 102 1", d, inst_w[d], inst_en_w[d]);
      end
    end
    step();
  endtask

  task automatic test_bulk();
    bit ok;
    wait_ready(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bulk_wait_ready: ready=0 after 60 cycles, want 1");
    end
    cmd_valid = 1'b1;
    cmd_kind  = 2'd2;
    cmd_index = 3'd5;
    cmd_data  = BULK_DATA;
    step();
    cmd_valid = 1'b0;
    // k counts edges since (and including) the accept edge.
    for (int k = 1; k <= 26; k++) begin
      for (int d = 0; d < 2; d++) begin
        int          period;
        int          nld;
        int          slot;
        logic [11:0] e_inst;
        logic        e_en, e_done, e_busy, e_rdy;
        period = (d == 0) ? 1 : 3;
        nld    = 8 * period;
        e_done = 1'b0;
        if (k <= nld) begin
          slot   = (k - 1) / period;
          e_inst = {4'(2 + slot), 8'(slot + 1)};
          e_en   = ((k - 1) % period) == 0;
          e_busy = 1'b1;
          e_rdy  = 1'b0;
        end else if (k == nld + 1) begin
          e_inst = 12'h105;
          e_en   = 1'b1;
          e_busy = 1'b1;
          e_rdy  = 1'b0;
        end else begin
          e_inst = 12'h105;
          e_en   = 1'b0;
          e_busy = 1'b0;
          e_rdy  = 1'b1;
          e_done = (k == nld + 2);
        end
        n_cmp++;
        if (inst_w[d] !== e_inst || inst_en_w[d] !== e_en || done_w[d] !== e_done ||
            busy_w[d] !== e_busy || cmd_ready_w[d] !== e_rdy) begin
          n_bad++;
          $display("FAIL bulk_k%0d dut%0d: inst=%h en=%b done=%b busy=%b rdy=%b, want %h %b %b %b %b",
                   k, d, inst_w[d], inst_en_w[d], done_w[d], busy_w[d], cmd_ready_w[d],
                   e_inst, e_en, e_done, e_busy, e_rdy);
        end
      end
      step();
    end
`ifdef REG_BANK_S8_CTL_SHADOW_EN
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (shadow_w[d] !== 8'h06) begin
        n_bad++;
        $display("FAIL bulk_shadow dut%0d: shadow_out=%h, want 06", d, shadow_w[d]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int en_seen;
    wait_ready(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL midrst_wait_ready: ready=0 after 60 cycles, want 1");
    end
    cmd_valid = 1'b1;
    cmd_kind  = 2'd2;
    cmd_index = 3'd5;
    cmd_data  = BULK_DATA;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    n_cmp++;
    if (inst_w[0] !== 12'h504 || inst_en_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_fourth_inst: inst=%h en=%b, want 504 1", inst_w[0], inst_en_w[0]);
    end
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (inst_en_w[d] !== 1'b0 || inst_w[d] !== 12'h000 || busy_w[d] !== 1'b1 || cmd_ready_w[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_async dut%0d: en=%b inst=%h busy=%b rdy=%b, want 0 000 1 0",
                 d, inst_en_w[d], inst_w[d], busy_w[d], cmd_ready_w[d]);
      end
    end
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (cmd_ready_w[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL midrst_startup%0d dut%0d: rdy=%b, want 0", c, d, cmd_ready_w[d]);
        end
      end
      step();
    end
    en_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (inst_en_w[0] || inst_en_w[1]) en_seen++;
      step();
    end
    n_cmp++;
    if (en_seen != 0) begin
      n_bad++;
      $display("FAIL midrst_no_replay: inst_en cycles=%0d, want 0", en_seen);
    end
  endtask

  task automatic test_error();
    bit ok;
    int en_seen;
    int rdy_seen;
    int err_low;
    wait_ready(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL error_wait_ready: ready=0 after 60 cycles, want 1");
    end
    cmd_valid = 1'b1;
    cmd_kind  = 2'd3;
    cmd_index = 3'd1;
    step();
    cmd_kind  = 2'd0;  // keep offering a legal LOAD; it must never be taken
    cmd_data  = 64'hFF;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (error_w[d] !== 1'b1 || inst_en_w[d] !== 1'b0 || cmd_ready_w[d] !== 1'b0 || busy_w[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL error_entry dut%0d: err=%b en=%b rdy=%b busy=%b, want 1 0 0 1",
                 d, error_w[d], inst_en_w[d], cmd_ready_w[d], busy_w[d]);
      end
    end
    en_seen  = 0;
    rdy_seen = 0;
    err_low  = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (inst_en_w[d] !== 1'b0 || done_w[d] !== 1'b0) en_seen++;
        if (cmd_ready_w[d] !== 1'b0) rdy_seen++;
        if (error_w[d] !== 1'b1) err_low++;
      end
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (en_seen != 0 || rdy_seen != 0 || err_low != 0) begin
      n_bad++;
      $display("FAIL error_sticky: en/done cycles=%0d rdy cycles=%0d err-low cycles=%0d, want 0 0 0",
               en_seen, rdy_seen, err_low);
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_back_to_back();
    test_bulk();
    test_reset_mid_burst();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000 ns, want finished");
    $fatal(1, "timeout");
  end

endmodule
